// File: rtl/fetch_unit.sv
// Instruction fetch stage: walks the PC, reads words over a req/ack handshake and
// presents one (optionally two-word) instruction at a time to decode.
module fetch_unit #(
    parameter int unsigned        ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_rdata,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    output logic [15:0]       instr,
    output logic [4:0]        opcode,
    output logic [15:0]       imm,
    output logic [ADDR_W-1:0] pc_out
);

    typedef enum logic [1:0] {
        StFetchOp,
        StFetchImm,
        StIssue
    } state_e;

    localparam logic [ADDR_W-1:0] PcInc = 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_out_q, pc_out_d;
    logic [15:0]       instr_q, instr_d;
    logic [15:0]       imm_q, imm_d;
    logic              valid_q, valid_d;
    logic              req_q, req_d;
    logic              ack_ok;

    // LDM, SHL and SHR carry an immediate in the following word.
    function automatic logic is_two_word(input logic [4:0] op);
        return (op == 5'd14) || (op == 5'd30) || (op == 5'd31);
    endfunction

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pc_out_d = pc_out_q;
        instr_d  = instr_q;
        imm_d    = imm_q;
        valid_d  = valid_q;
        // An ack is only meaningful while a request is actually outstanding.
        ack_ok   = imem_ack & req_q;

        if (redirect) begin
            pc_d    = redirect_pc;
            valid_d = 1'b0;
            state_d = StFetchOp;
        end else begin
            unique case (state_q)
                StFetchOp: begin
                    if (ack_ok) begin
                        instr_d  = imem_rdata;
                        pc_out_d = pc_q;
                        pc_d     = pc_q + PcInc;
                        if (is_two_word(imem_rdata[15:11])) begin
                            state_d = StFetchImm;
                        end else begin
                            imm_d   = '0;
                            valid_d = 1'b1;
                            state_d = StIssue;
                        end
                    end
                end
                StFetchImm: begin
                    if (ack_ok) begin
                        imm_d   = imem_rdata;
                        pc_d    = pc_q + PcInc;
                        valid_d = 1'b1;
                        state_d = StIssue;
                    end
                end
                StIssue: begin
                    if (!stall) begin
                        valid_d = 1'b0;
                        state_d = StFetchOp;
                    end
                end
                default: state_d = StFetchOp;
            endcase
        end

        // Request is registered so it stays low throughout reset and needs no input path.
        req_d = (state_d != StIssue);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StFetchOp;
            pc_q     <= RESET_PC;
            pc_out_q <= '0;
            instr_q  <= '0;
            imm_q    <= '0;
            valid_q  <= 1'b0;
            req_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pc_out_q <= pc_out_d;
            instr_q  <= instr_d;
            imm_q    <= imm_d;
            valid_q  <= valid_d;
            req_q    <= req_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[15:11];
    assign imm         = imm_q;
    assign pc_out      = pc_out_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// against a program-order reference model with a random-latency memory.
module tb_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, imem_req, imem_ack, stall, redirect, instr_valid;
    logic [15:0] imem_addr, imem_rdata, redirect_pc, instr, imm, pc_out;
    logic [4:0]  opcode;

    logic        w_rst_n, w_imem_req, w_imem_ack, w_stall, w_redirect, w_instr_valid;
    logic [15:0] w_imem_addr, w_imem_rdata, w_redirect_pc, w_instr, w_imm, w_pc_out;
    logic [4:0]  w_opcode;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [15:0] mem [0:65535];

    fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .instr_valid(instr_valid), .instr(instr),
        .opcode(opcode), .imm(imm), .pc_out(pc_out)
    );

    fetch_unit #(.ADDR_W(16), .RESET_PC(16'hFFFF)) dut_w (
        .clk(clk), .rst_n(w_rst_n), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
        .imem_ack(w_imem_ack), .imem_rdata(w_imem_rdata), .stall(w_stall),
        .redirect(w_redirect), .redirect_pc(w_redirect_pc), .instr_valid(w_instr_valid),
        .instr(w_instr), .opcode(w_opcode), .imm(w_imm), .pc_out(w_pc_out)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; imem_ack = 1'b0; stall = 1'b0; redirect = 1'b0;
        redirect_pc = 16'h0; imem_rdata = 16'h0;
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    function automatic bit two_word(input logic [15:0] w);
        logic [4:0] op;
        op = w[15:11];
        return (op == 5'd14) || (op == 5'd30) || (op == 5'd31);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; imem_ack = 1'b0; stall = 1'b0; redirect = 1'b0;
        redirect_pc = 16'h0; imem_rdata = 16'h0;
        step();
        n_cmp++;
        if ({imem_req, instr_valid, instr} !== {1'b0, 1'b0, 16'h0}) begin
            n_fail++;
            $display("FAIL reset_1: req/valid/instr=%b/%b/%h required 0/0/0000",
                     imem_req, instr_valid, instr);
        end
        // Reset must win over a simultaneous ack and redirect.
        imem_ack = 1'b1; imem_rdata = 16'hC800; redirect = 1'b1; redirect_pc = 16'h0055;
        step();
        n_cmp++;
        if ({imem_req, instr_valid, instr, imm, opcode, pc_out} !== {2'b00, 16'h0, 16'h0, 5'd0, 16'h0}) begin
            n_fail++;
            $display("FAIL reset_2: req=%b valid=%b instr=%h imm=%h op=%0d pc_out=%h required all 0",
                     imem_req, instr_valid, instr, imm, opcode, pc_out);
        end
        imem_ack = 1'b0; redirect = 1'b0; rst_n = 1'b1;
        step();
        n_cmp++;
        if ({imem_req, imem_addr, instr_valid} !== {1'b1, 16'h0000, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_release: req=%b addr=%h valid=%b required 1/0000/0",
                     imem_req, imem_addr, instr_valid);
        end
    endtask

    task automatic test_one_word();
        do_reset();
        imem_ack = 1'b1; imem_rdata = 16'hC800;
        step();
        imem_ack = 1'b0;
        n_cmp++;
        if ({instr_valid, opcode, imm, pc_out, instr, imem_req} !==
            {1'b1, 5'd25, 16'h0, 16'h0, 16'hC800, 1'b0}) begin
            n_fail++;
            $display("FAIL one_word_issue: valid=%b op=%0d imm=%h pc_out=%h instr=%h req=%b required 1/25/0000/0000/c800/0",
                     instr_valid, opcode, imm, pc_out, instr, imem_req);
        end
        step();
        n_cmp++;
        if ({imem_req, imem_addr, instr_valid} !== {1'b1, 16'h0001, 1'b0}) begin
            n_fail++;
            $display("FAIL one_word_next: req=%b addr=%h valid=%b required 1/0001/0",
                     imem_req, imem_addr, instr_valid);
        end
    endtask

    task automatic test_two_word();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin
                n_fail++;
                $display("FAIL two_word_op_addr[%0d]: req=%b addr=%h required 1/0000",
                         i, imem_req, imem_addr);
            end
            imem_ack = (i == 1); imem_rdata = 16'h7000;
            step();
        end
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({imem_req, imem_addr, instr_valid} !== {1'b1, 16'h0001, 1'b0}) begin
                n_fail++;
                $display("FAIL two_word_imm_addr[%0d]: req=%b addr=%h valid=%b required 1/0001/0",
                         i, imem_req, imem_addr, instr_valid);
            end
            imem_ack = (i == 1); imem_rdata = 16'h1234;
            step();
        end
        imem_ack = 1'b0;
        n_cmp++;
        if ({instr_valid, instr, imm, pc_out, opcode} !== {1'b1, 16'h7000, 16'h1234, 16'h0, 5'd14}) begin
            n_fail++;
            $display("FAIL two_word_issue: valid=%b instr=%h imm=%h pc_out=%h op=%0d required 1/7000/1234/0000/14",
                     instr_valid, instr, imm, pc_out, opcode);
        end
        step();
        n_cmp++;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0002}) begin
            n_fail++;
            $display("FAIL two_word_next: req=%b addr=%h required 1/0002", imem_req, imem_addr);
        end
    endtask

    task automatic test_stall();
        do_reset();
        imem_ack = 1'b1; imem_rdata = 16'h08A5;
        step();
        imem_ack = 1'b0; stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) stall = 1'b0;
            n_cmp++;
            if ({instr_valid, instr, imm, pc_out, imem_req} !== {1'b1, 16'h08A5, 16'h0, 16'h0, 1'b0}) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: valid=%b instr=%h imm=%h pc_out=%h req=%b required 1/08a5/0000/0000/0",
                         i, instr_valid, instr, imm, pc_out, imem_req);
            end
            step();
        end
        n_cmp++;
        if ({imem_req, imem_addr, instr_valid} !== {1'b1, 16'h0001, 1'b0}) begin
            n_fail++;
            $display("FAIL stall_release: req=%b addr=%h valid=%b required 1/0001/0",
                     imem_req, imem_addr, instr_valid);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        imem_ack = 1'b1; imem_rdata = 16'h7000;
        step();
        // Now fetching the immediate: redirect coincides with its ack.
        imem_ack = 1'b1; imem_rdata = 16'hBEEF; redirect = 1'b1; redirect_pc = 16'h0040;
        step();
        redirect = 1'b0;
        n_cmp++;
        if ({imem_req, imem_addr, instr_valid} !== {1'b1, 16'h0040, 1'b0}) begin
            n_fail++;
            $display("FAIL redirect_imm: req=%b addr=%h valid=%b required 1/0040/0",
                     imem_req, imem_addr, instr_valid);
        end
        imem_ack = 1'b1; imem_rdata = 16'hC800;
        step();
        imem_ack = 1'b0;
        n_cmp++;
        if ({instr_valid, instr, imm, pc_out} !== {1'b1, 16'hC800, 16'h0, 16'h0040}) begin
            n_fail++;
            $display("FAIL redirect_target_issue: valid=%b instr=%h imm=%h pc_out=%h required 1/c800/0000/0040",
                     instr_valid, instr, imm, pc_out);
        end
        stall = 1'b1; redirect = 1'b1; redirect_pc = 16'h0010;
        step();
        stall = 1'b0; redirect = 1'b0;
        n_cmp++;
        if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 16'h0010}) begin
            n_fail++;
            $display("FAIL redirect_over_stall: valid=%b req=%b addr=%h required 0/1/0010",
                     instr_valid, imem_req, imem_addr);
        end
    endtask

    task automatic test_wrap();
        w_rst_n = 1'b0; w_imem_ack = 1'b0; w_stall = 1'b0; w_redirect = 1'b0;
        w_redirect_pc = 16'h0; w_imem_rdata = 16'h0;
        step(); step();
        w_rst_n = 1'b1;
        step();
        n_cmp++;
        if ({w_imem_req, w_imem_addr} !== {1'b1, 16'hFFFF}) begin
            n_fail++;
            $display("FAIL wrap_start: req=%b addr=%h required 1/ffff", w_imem_req, w_imem_addr);
        end
        w_imem_ack = 1'b1; w_imem_rdata = 16'h7000;
        step();
        n_cmp++;
        if ({w_imem_req, w_imem_addr} !== {1'b1, 16'h0000}) begin
            n_fail++;
            $display("FAIL wrap_imm_addr: req=%b addr=%h required 1/0000", w_imem_req, w_imem_addr);
        end
        w_imem_rdata = 16'h5555;
        step();
        w_imem_ack = 1'b0;
        n_cmp++;
        if ({w_instr_valid, w_instr, w_imm, w_pc_out} !== {1'b1, 16'h7000, 16'h5555, 16'hFFFF}) begin
            n_fail++;
            $display("FAIL wrap_issue: valid=%b instr=%h imm=%h pc_out=%h required 1/7000/5555/ffff",
                     w_instr_valid, w_instr, w_imm, w_pc_out);
        end
        step();
        n_cmp++;
        if ({w_imem_req, w_imem_addr} !== {1'b1, 16'h0001}) begin
            n_fail++;
            $display("FAIL wrap_next: req=%b addr=%h required 1/0001", w_imem_req, w_imem_addr);
        end
    endtask

    task automatic test_random();
        logic [15:0] exp_pc, pend_pc, e_instr, e_imm;
        bit          pend, busy, timed_out;
        int          lat, idle, issued;

        for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
        do_reset();
        exp_pc = 16'h0; pend = 1'b0; busy = 1'b0; lat = 0; idle = 0; issued = 0;
        timed_out = 1'b0; pend_pc = 16'h0;

        for (int cyc = 0; cyc < 3000 && !timed_out; cyc++) begin
            if (pend) begin
                n_cmp++;
                if ({imem_req, imem_addr, instr_valid} !== {1'b1, pend_pc, 1'b0}) begin
                    n_fail++;
                    $display("FAIL rand_redirect cyc %0d: req=%b addr=%h valid=%b required 1/%h/0",
                             cyc, imem_req, imem_addr, instr_valid, pend_pc);
                end
                exp_pc = pend_pc;
                pend   = 1'b0;
            end
            if (instr_valid) begin
                idle    = 0;
                e_instr = mem[exp_pc];
                e_imm   = two_word(e_instr) ? mem[exp_pc + 16'd1] : 16'h0;
                n_cmp++;
                if ({instr, opcode, imm, pc_out, imem_req} !==
                    {e_instr, e_instr[15:11], e_imm, exp_pc, 1'b0}) begin
                    n_fail++;
                    $display("FAIL rand_issue cyc %0d: instr=%h op=%0d imm=%h pc_out=%h req=%b required %h/%0d/%h/%h/0",
                             cyc, instr, opcode, imm, pc_out, imem_req,
                             e_instr, e_instr[15:11], e_imm, exp_pc);
                end
            end else begin
                idle++;
                if (idle > 200) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL rand_timeout cyc %0d: no instr_valid for %0d cycles required <= 200",
                             cyc, idle);
                    timed_out = 1'b1;
                end
            end

            redirect = ($urandom_range(0, 19) == 0);
            if (redirect) begin
                redirect_pc = 16'($urandom_range(0, 511));
                pend        = 1'b1;
                pend_pc     = redirect_pc;
            end
            stall = ($urandom_range(0, 2) == 0);
            if (instr_valid && !stall && !redirect) begin
                exp_pc = exp_pc + (two_word(mem[exp_pc]) ? 16'd2 : 16'd1);
                issued++;
            end

            if (imem_req) begin
                if (!busy) begin
                    busy = 1'b1;
                    lat  = $urandom_range(0, 2);
                end
                if (lat == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem[imem_addr];
                    busy       = 1'b0;
                end else begin
                    imem_ack   = 1'b0;
                    imem_rdata = 16'($urandom);
                    lat--;
                end
            end else begin
                // Stray acks with garbage data while idle must be ignored.
                busy       = 1'b0;
                imem_ack   = ($urandom_range(0, 7) == 0);
                imem_rdata = 16'($urandom);
            end
            step();
        end
        imem_ack = 1'b0; stall = 1'b0; redirect = 1'b0;
        n_cmp++;
        if (issued < 100) begin
            n_fail++;
            $display("FAIL rand_throughput: issued=%0d required >= 100", issued);
        end
    endtask

    initial begin
        w_rst_n = 1'b0; w_imem_ack = 1'b0; w_stall = 1'b0; w_redirect = 1'b0;
        w_redirect_pc = 16'h0; w_imem_rdata = 16'h0;
        test_reset();
        test_one_word();
        test_two_word();
        test_stall();
        test_redirect();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
